// File: rtl/dds_sweep_pkg.sv
// Shared constants and types for the DDS frequency sweep controller.
// Optional marker feature is enabled with DDS_SWEEP_MARKER_EN.
package dds_sweep_pkg;

    localparam int FW_WIDTH_DEF    = 32;
    localparam int DWELL_WIDTH_DEF = 24;

    localparam logic [1:0] SWEEP_SINGLE = 2'b00;
    localparam logic [1:0] SWEEP_SAW    = 2'b01;
    localparam logic [1:0] SWEEP_TRI    = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        UP   = 2'b01,
        DOWN = 2'b10
    } sweep_state_t;

endpackage

// File: rtl/dds_sweep_dwell_timer.sv
// Dwell down-counter: expire is high on the last cycle of each dwell period.
// Reloads from the value captured at load, or from that captured value on expire.
module dds_sweep_dwell_timer
    import dds_sweep_pkg::*;
#(
    parameter int DWELL_WIDTH = DWELL_WIDTH_DEF
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   run,
    input  logic [DWELL_WIDTH-1:0] load_val,
    output logic                   expire
);

    logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
    logic [DWELL_WIDTH-1:0] reload_q, reload_d;

    always_comb begin
        cnt_d    = cnt_q;
        reload_d = reload_q;
        expire   = run && !load && (cnt_q == '0);
        if (load) begin
            cnt_d    = load_val;
            reload_d = load_val;
        end else if (expire) begin
            cnt_d = reload_q;
        end else if (run) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            cnt_q    <= '0;
            reload_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
        end
    end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-word sweep (single / sawtooth / triangle) feeding the DDS core.
// Define DDS_SWEEP_MARKER_EN to add the marker_word input and marker crossing pulse.
module dds_sweep_ctrl
    import dds_sweep_pkg::*;
#(
    parameter int FW_WIDTH    = FW_WIDTH_DEF,
    parameter int DWELL_WIDTH = DWELL_WIDTH_DEF
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [1:0]             mode,
    input  logic [FW_WIDTH-1:0]    start_word,
    input  logic [FW_WIDTH-1:0]    stop_word,
    input  logic [FW_WIDTH-1:0]    step_word,
    input  logic [DWELL_WIDTH-1:0] dwell_cnt,
`ifdef DDS_SWEEP_MARKER_EN
    input  logic [FW_WIDTH-1:0]    marker_word,
    output logic                   marker,
`endif
    output logic [FW_WIDTH-1:0]    fre_word,
    output logic                   busy,
    output logic                   done
);

    sweep_state_t          state_q, state_d;
    logic [FW_WIDTH-1:0]   fre_q, fre_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [1:0]            mode_q, mode_d;
    logic [FW_WIDTH-1:0]   start_q, start_d;
    logic [FW_WIDTH-1:0]   stop_q, stop_d;
    logic [FW_WIDTH-1:0]   step_q, step_d;
    logic                  degen_q, degen_d;

    logic                  timer_load;
    logic                  expire;
    logic [FW_WIDTH:0]     up_sum;
    logic [FW_WIDTH:0]     dn_dif;
    logic [FW_WIDTH-1:0]   up_nxt;
    logic [FW_WIDTH-1:0]   dn_nxt;
    logic                  at_stop;
    logic                  at_start;

    dds_sweep_dwell_timer #(.DWELL_WIDTH(DWELL_WIDTH)) u_dwell (
        .clock    (clock),
        .rst      (rst),
        .load     (timer_load),
        .run      (state_q != IDLE),
        .load_val (dwell_cnt),
        .expire   (expire)
    );

    // Extra bit catches carry/borrow so the endpoints clamp instead of wrapping.
    always_comb begin
        up_sum   = {1'b0, fre_q} + {1'b0, step_q};
        dn_dif   = {1'b0, fre_q} - {1'b0, step_q};
        up_nxt   = (up_sum[FW_WIDTH] || (up_sum[FW_WIDTH-1:0] >= stop_q))  ? stop_q  : up_sum[FW_WIDTH-1:0];
        dn_nxt   = (dn_dif[FW_WIDTH] || (dn_dif[FW_WIDTH-1:0] <= start_q)) ? start_q : dn_dif[FW_WIDTH-1:0];
        at_stop  = (fre_q == stop_q);
        at_start = (fre_q == start_q);
    end

    always_comb begin
        state_d    = state_q;
        fre_d      = fre_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        mode_d     = mode_q;
        start_d    = start_q;
        stop_d     = stop_q;
        step_d     = step_q;
        degen_d    = degen_q;
        timer_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d     = mode;
                    start_d    = start_word;
                    stop_d     = stop_word;
                    step_d     = step_word;
                    degen_d    = (step_word == '0) || (start_word >= stop_word);
                    fre_d      = start_word;
                    busy_d     = 1'b1;
                    state_d    = UP;
                    timer_load = 1'b1;
                end
            end
            UP: begin
                if (expire) begin
                    if (degen_q || at_stop) begin
                        if (!degen_q && mode_q == SWEEP_SAW) begin
                            fre_d = start_q;
                        end else if (!degen_q && mode_q == SWEEP_TRI) begin
                            fre_d   = dn_nxt;
                            state_d = DOWN;
                        end else begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end
                    end else begin
                        fre_d = up_nxt;
                    end
                end
            end
            DOWN: begin
                if (expire) begin
                    if (at_start) begin
                        fre_d   = up_nxt;
                        state_d = UP;
                    end else begin
                        fre_d = dn_nxt;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
        // Abort overrides everything, including a start in the same cycle.
        if (abort) begin
            state_d    = IDLE;
            fre_d      = fre_q;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            timer_load = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= IDLE;
            fre_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mode_q  <= SWEEP_SINGLE;
            start_q <= '0;
            stop_q  <= '0;
            step_q  <= '0;
            degen_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fre_q   <= fre_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mode_q  <= mode_d;
            start_q <= start_d;
            stop_q  <= stop_d;
            step_q  <= step_d;
            degen_q <= degen_d;
        end
    end

`ifdef DDS_SWEEP_MARKER_EN
    logic [FW_WIDTH-1:0] mk_word_q, mk_word_d;
    logic                marker_q, marker_d;
    logic                cross_up;
    logic                cross_dn;

    always_comb begin
        mk_word_d = mk_word_q;
        marker_d  = 1'b0;
        cross_up  = (fre_q < mk_word_q) && (mk_word_q <= fre_d);
        cross_dn  = (fre_q > mk_word_q) && (mk_word_q >= fre_d);
        if (!abort) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mk_word_d = marker_word;
                        marker_d  = (start_word == marker_word);
                    end
                end
                UP: begin
                    if (expire) begin
                        if (degen_q || at_stop) begin
                            // The sawtooth wrap only counts when it lands exactly on the marker.
                            if (!degen_q && mode_q == SWEEP_SAW) begin
                                marker_d = (start_q == mk_word_q);
                            end else if (!degen_q && mode_q == SWEEP_TRI) begin
                                marker_d = cross_dn;
                            end
                        end else begin
                            marker_d = cross_up;
                        end
                    end
                end
                DOWN: begin
                    if (expire) begin
                        marker_d = at_start ? cross_up : cross_dn;
                    end
                end
                default: marker_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            mk_word_q <= '0;
            marker_q  <= 1'b0;
        end else begin
            mk_word_q <= mk_word_d;
            marker_q  <= marker_d;
        end
    end

    assign marker = marker_q;
`endif

    assign fre_word = fre_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
